segment_reader: RTL and testbench

Inverse of the team's seven-segment decoder. It samples a multiplexed, active-low 7-segment bus and its one-hot digit-select strobes, for example from a scanned external display or a looped-back HEX bus in test. Each stable pattern is translated back to its 4-bit hex value. A frame of NDIGITS nibbles is assembled and presented with a one-cycle valid pulse and an error flag. It sits between a scanned display source and the frequency-interpreter datapath or checker logic.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_pattern_lookup.sv | 23 ++
 rtl/segment_reader.sv | 110 +++++++++++
 tb/tb_segment_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the display encoder and decoder.
// Segments are active-low; bit0 = a through bit6 = g.
package seg_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry i is the active-low pattern for hex digit i.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    return SEG_PATTERNS[nibble];
  endfunction

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational inverse of the segment table: 7-bit pattern -> {hit, nibble}.
// Unrecognised patterns give hit = 0 and nibble = 0.
module seg_pattern_lookup
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       hit_o,
  output logic [3:0] nibble_o
);

  // Table entries are unique, so at most one iteration matches.
  always_comb begin
    hit_o    = 1'b0;
    nibble_o = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == SEG_PATTERNS[i]) begin
        hit_o    = 1'b1;
        nibble_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/segment_reader.sv
// Samples a multiplexed active-low seven-segment bus, debounces each digit and
// reassembles a frame of NDIGITS hex nibbles with a one-cycle valid pulse.
module segment_reader
  import seg_pkg::*;
#(
  parameter int unsigned NDIGITS       = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [6:0]             seg_in,
  input  logic [NDIGITS-1:0]     dig_sel,
  output logic [4*NDIGITS-1:0]   value,
  output logic                   valid,
  output logic                   frame_err
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  logic [6:0]                seg_q, prev_seg_q;
  logic [NDIGITS-1:0]        sel_q, prev_sel_q;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [NDIGITS-1:0][3:0]   shadow_q, shadow_d;
  logic [NDIGITS-1:0]        got_q, got_d;
  logic [NDIGITS-1:0]        err_q, err_d;
  logic [4*NDIGITS-1:0]      value_q, value_d;
  logic                      valid_q, valid_d;
  logic                      frame_err_q, frame_err_d;

  logic                      sel_onehot;
  logic                      changed;
  logic                      accept;
  logic                      complete;
  logic                      lk_hit;
  logic [3:0]                lk_nibble;

  seg_pattern_lookup u_lookup (
    .pattern_i (seg_q),
    .hit_o     (lk_hit),
    .nibble_o  (lk_nibble)
  );

  // Stability counter; accept fires on the single cycle the count reaches the threshold.
  always_comb begin
    sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - NDIGITS'(1))) == '0);
    changed    = (seg_q != prev_seg_q) || (sel_q != prev_sel_q);
    cnt_d      = cnt_q;
    if (!sel_onehot) begin
      cnt_d = '0;
    end else if (changed) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
    accept = sel_onehot && (cnt_d == CntMax) && (cnt_q != CntMax);
  end

  // Frame assembly; a capture landing in the completion cycle starts the next frame.
  always_comb begin
    complete    = &got_q;
    shadow_d    = shadow_q;
    got_d       = complete ? '0 : got_q;
    err_d       = complete ? '0 : err_q;
    value_d     = complete ? shadow_q : value_q;
    frame_err_d = complete ? (|err_q) : frame_err_q;
    valid_d     = complete;
    for (int i = 0; i < NDIGITS; i++) begin
      if (accept && sel_q[i]) begin
        shadow_d[i] = lk_nibble;
        got_d[i]    = 1'b1;
        err_d[i]    = ~lk_hit;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      seg_q       <= '0;
      sel_q       <= '0;
      prev_seg_q  <= '0;
      prev_sel_q  <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      got_q       <= '0;
      err_q       <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      seg_q       <= seg_in;
      sel_q       <= dig_sel;
      prev_seg_q  <= seg_q;
      prev_sel_q  <= sel_q;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      got_q       <= got_d;
      err_q       <= err_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_segment_reader.sv
// Directed bench for segment_reader: one single-digit and one four-digit instance.
module tb_segment_reader;

  logic        clock = 1'b0;
  logic        resetn;
  logic [6:0]  seg1, seg4;
  logic        sel1;
  logic [3:0]  sel4;
  logic [3:0]  value1;
  logic [15:0] value4;
  logic        valid1, valid4, err1, err4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0]  v1_q [$];
  logic        e1_q [$];
  logic [15:0] v4_q [$];
  logic        e4_q [$];

  always #5 clock = ~clock;

  segment_reader #(.NDIGITS(1), .STABLE_CYCLES(4)) u_dut1 (
    .clock     (clock),
    .resetn    (resetn),
    .seg_in    (seg1),
    .dig_sel   (sel1),
    .value     (value1),
    .valid     (valid1),
    .frame_err (err1)
  );

  segment_reader #(.NDIGITS(4), .STABLE_CYCLES(4)) u_dut4 (
    .clock     (clock),
    .resetn    (resetn),
    .seg_in    (seg4),
    .dig_sel   (sel4),
    .value     (value4),
    .valid     (valid4),
    .frame_err (err4)
  );

  // Record every valid pulse, sampled mid-cycle.
  always @(negedge clock) begin
    if (valid1) begin
      v1_q.push_back(value1);
      e1_q.push_back(err1);
    end
    if (valid4) begin
      v4_q.push_back(value4);
      e4_q.push_back(err4);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic present4(input logic [3:0] sel, input logic [6:0] seg, input int n);
    sel4 = sel;
    seg4 = seg;
    cycles(n);
  endtask

  task automatic frame4(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
    present4(4'b0001, p0, 5);
    present4(4'b0010, p1, 5);
    present4(4'b0100, p2, 5);
    present4(4'b1000, p3, 5);
  endtask

  task automatic check_frame4(input string tag, input logic [15:0] exp_v, input logic exp_e);
    logic [15:0] v;
    logic        e;
    present4(4'b0000, 7'h7F, 3);
    v = (v4_q.size() > 0) ? v4_q[0] : 16'hxxxx;
    e = (e4_q.size() > 0) ? e4_q[0] : 1'bx;
    check_eq({tag, "_pulses"}, v4_q.size(), 1);
    check_eq({tag, "_value"}, v, exp_v);
    check_eq({tag, "_err"}, e, exp_e);
    v4_q.delete();
    e4_q.delete();
  endtask

  initial begin
    logic [3:0] v;
    logic       e;
    resetn = 1'b0;
    seg1 = 7'h7F;
    sel1 = 1'b0;
    seg4 = 7'h7F;
    sel4 = 4'b0000;
    cycles(2);
    check_eq("rst_value4", value4, 16'h0000);
    check_eq("rst_valid4", valid4, 0);
    check_eq("rst_err4", err4, 0);
    check_eq("rst_value1", value1, 0);
    check_eq("rst_valid1", valid1, 0);
    resetn = 1'b1;
    cycles(2);

    // Walk all 16 patterns on the single-digit instance.
    sel1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      seg1 = pat[i];
      cycles(6);
    end
    sel1 = 1'b0;
    cycles(3);
    check_eq("walk_pulses", v1_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      v = (i < v1_q.size()) ? v1_q[i] : 4'hx;
      e = (i < e1_q.size()) ? e1_q[i] : 1'bx;
      check_eq($sformatf("walk_value_%0d", i), v, i);
      check_eq($sformatf("walk_err_%0d", i), e, 0);
    end
    check_eq("walk_hold", value1, 4'hF);

    // Basic four-digit frame.
    v4_q.delete();
    e4_q.delete();
    frame4(7'h30, 7'h40, 7'h79, 7'h24);
    check_frame4("basic", 16'h2103, 1'b0);
    check_eq("basic_hold", value4, 16'h2103);

    // Short glitch on digit 1 must not be captured.
    present4(4'b0001, 7'h30, 5);
    present4(4'b0010, 7'h79, 3);
    present4(4'b0010, 7'h24, 5);
    present4(4'b0100, 7'h79, 5);
    present4(4'b1000, 7'h24, 5);
    check_frame4("glitch", 16'h2123, 1'b0);

    // Blank pattern on digit 2 flags the frame; the next clean frame clears it.
    frame4(7'h40, 7'h79, 7'h7F, 7'h24);
    check_frame4("bad", 16'h2010, 1'b1);
    check_eq("bad_err_hold", err4, 1);
    frame4(7'h02, 7'h78, 7'h00, 7'h10);
    check_frame4("clean", 16'h9876, 1'b0);

    // Non-one-hot selects capture nothing and keep the partial frame.
    present4(4'b0001, 7'h19, 5);
    present4(4'b0010, 7'h12, 5);
    present4(4'b0100, 7'h02, 5);
    present4(4'b0000, 7'h40, 10);
    present4(4'b0011, 7'h40, 10);
    check_eq("nohot_pulses", v4_q.size(), 0);
    check_eq("nohot_hold", value4, 16'h9876);
    present4(4'b1000, 7'h78, 5);
    check_frame4("nohot_done", 16'h7654, 1'b0);

    // Reset mid-frame discards the partial frame.
    present4(4'b0001, 7'h40, 5);
    present4(4'b0010, 7'h79, 5);
    present4(4'b0100, 7'h24, 5);
    sel4 = 4'b0000;
    resetn = 1'b0;
    cycles(1);
    resetn = 1'b1;
    present4(4'b0000, 7'h7F, 4);
    check_eq("mid_rst_pulses", v4_q.size(), 0);
    check_eq("mid_rst_value", value4, 16'h0000);
    check_eq("mid_rst_err", err4, 0);
    frame4(7'h03, 7'h46, 7'h21, 7'h06);
    check_frame4("post_rst", 16'hEDCB, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
